// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - handshaked fetch/execute sequencer driving PC controls and memory requests
module pc_fetch_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        i_ack,
    input  logic [31:0] instr_data,
    input  logic        d_ack,
    input  logic        alu_branch,
    input  logic        halt,
    output logic        i_req,
    output logic        d_read,
    output logic        d_write,
    output logic [31:0] instr,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        pc_branch,
    output logic        pc_disable,
    output logic        reg_write,
    output logic        illegal_instr,
    output logic        fault
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Last count value that may still be followed by an ack; one more idle cycle faults.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_COMMIT, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        i_req_q, i_req_d;
    logic        d_read_q, d_read_d;
    logic        d_write_q, d_write_d;
    logic        pc_inc_q, pc_inc_d;
    logic        pc_load_q, pc_load_d;
    logic        pc_branch_q, pc_branch_d;
    logic        pc_disable_q, pc_disable_d;
    logic        reg_write_q, reg_write_d;
    logic        illegal_q, illegal_d;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_ALU, OP_ALUI, OP_LUI,
            OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: op_legal = 1'b1;
            default:                              op_legal = 1'b0;
        endcase
    endfunction

    // Next state plus the output values that must be visible in that next state.
    always_comb begin
        logic [6:0] nxt_op;
        logic       commit_d;
        state_d   = state_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE:   state_d = halt ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (i_ack) begin
                    instr_d   = instr_data;
                    illegal_d = !op_legal(instr_data[6:0]);
                    state_d   = S_EXEC;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (instr_q[6:0] == OP_LOAD || instr_q[6:0] == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_MEM: begin
                if (d_ack) begin
                    state_d = S_COMMIT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_COMMIT: state_d = halt ? S_HALT : S_FETCH;
            S_HALT: begin
                // A timeout fault pins the sequencer here until clr.
                if (!fault_q && !halt) begin
                    state_d = S_FETCH;
                end
            end
            default:  state_d = S_IDLE;
        endcase

        // Every fresh memory wait starts counting from zero.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            cnt_d = 8'd0;
        end

        nxt_op       = instr_d[6:0];
        commit_d     = (state_d == S_COMMIT);
        i_req_d      = (state_d == S_FETCH);
        d_read_d     = (state_d == S_MEM) && (nxt_op == OP_LOAD);
        d_write_d    = (state_d == S_MEM) && (nxt_op == OP_STORE);
        pc_branch_d  = commit_d && (nxt_op == OP_BRANCH) && alu_branch;
        pc_load_d    = commit_d && (nxt_op == OP_JAL || nxt_op == OP_JALR);
        pc_inc_d     = commit_d && !pc_branch_d && !pc_load_d;
        reg_write_d  = commit_d && op_legal(nxt_op) && (nxt_op != OP_BRANCH) && (nxt_op != OP_STORE);
        pc_disable_d = !commit_d;
    end

    // Sequencer state and registered outputs; clr drops every request immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= S_IDLE;
            instr_q      <= 32'd0;
            cnt_q        <= 8'd0;
            fault_q      <= 1'b0;
            i_req_q      <= 1'b0;
            d_read_q     <= 1'b0;
            d_write_q    <= 1'b0;
            pc_inc_q     <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_branch_q  <= 1'b0;
            pc_disable_q <= 1'b1;
            reg_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            i_req_q      <= i_req_d;
            d_read_q     <= d_read_d;
            d_write_q    <= d_write_d;
            pc_inc_q     <= pc_inc_d;
            pc_load_q    <= pc_load_d;
            pc_branch_q  <= pc_branch_d;
            pc_disable_q <= pc_disable_d;
            reg_write_q  <= reg_write_d;
            illegal_q    <= illegal_d;
        end
    end

    assign i_req         = i_req_q;
    assign d_read        = d_read_q;
    assign d_write       = d_write_q;
    assign instr         = instr_q;
    assign pc_inc        = pc_inc_q;
    assign pc_load       = pc_load_q;
    assign pc_branch     = pc_branch_q;
    assign pc_disable    = pc_disable_q;
    assign reg_write     = reg_write_q;
    assign illegal_instr = illegal_q;
    assign fault         = fault_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Multi-cycle sequencer that drives the program counter's control inputs (inc, load, ALU_out, Disable) and the instruction/data memory request handshakes.
- Fetches an instruction, classifies its opcode and waits for any data-memory access to finish.
- Then issues exactly one PC update and one register-write strobe per instruction.
- Sits between the PC, the memory interface and the register file; it replaces free-running PC increments with a handshaked fetch/execute loop.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for any memory ack before faulting (1..255)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
i_ack  input  1  instruction memory ack; instr_data valid this cycle
instr_data  input  32  instruction word from memory
d_ack  input  1  data memory ack for load/store
alu_branch  input  1  branch condition result from ALU
halt  input  1  request to stop before the next fetch
i_req  output  1  instruction fetch request, held until i_ack
d_read  output  1  data read request, held until d_ack
d_write  output  1  data write request, held until d_ack
instr  output  32  latched current instruction
pc_inc  output  1  to PC inc: PC+4
pc_load  output  1  to PC load: jump target (JAL/JALR)
pc_branch  output  1  to PC ALU_out: PC+imm
pc_disable  output  1  to PC Disable: freeze PC
reg_write  output  1  register-file write strobe
illegal_instr  output  1  one-cycle pulse on unknown opcode
fault  output  1  sticky memory-timeout flag

Behaviour:
- Async reset (clr=0): state=IDLE, instr=0, timeout counter=0, fault=0. All outputs 0 except pc_disable=1. Applies immediately, including mid-fetch or mid-memory access; outstanding requests drop the same instant.
- States: IDLE, FETCH, EXEC, MEM, COMMIT, HALT.
- IDLE: one cycle after clr release. Next state is HALT if halt=1, else FETCH.
- FETCH: i_req=1.
  - On i_ack=1: instr<=instr_data, go to EXEC. An ack in the first FETCH cycle is accepted, so minimum fetch = 1 cycle.
- EXEC: one cycle. Decode instr[6:0]:
  - 0000011 LOAD or 0100011 STORE -> MEM.
  - 0110011, 0010011, 0110111, 0010111, 1100011, 1101111, 1100111 -> COMMIT.
  - Any other opcode -> illegal_instr=1 this cycle, then COMMIT treated as NOP.
- MEM: d_read=1 (LOAD) or d_write=1 (STORE); never both. On d_ack=1 -> COMMIT.
- COMMIT: one cycle, exactly one PC control is high:
  - pc_branch=1 if opcode 1100011 and alu_branch=1.
  - pc_load=1 for 1101111/1100111.
  - Otherwise pc_inc=1, including a not-taken branch and an illegal opcode.
  - reg_write=1 for every legal opcode except 1100011 and 0100011.
  - Next state is HALT if halt=1, else FETCH.
- HALT: all requests 0. Leave to FETCH on the first cycle halt=0.
- pc_disable=1 in every state except COMMIT; pc_disable=0 in COMMIT.
- pc_inc, pc_load, pc_branch and reg_write are 0 outside COMMIT.
- Timeout:
  - An 8-bit counter clears on entry to FETCH/MEM and increments each cycle without an ack.
  - If it reaches MEM_TIMEOUT: fault<=1, go to HALT and stay there regardless of halt, until clr.
  - An ack arriving in the same cycle the count hits MEM_TIMEOUT wins; no fault.
- halt sampled in EXEC or MEM is ignored until COMMIT. An in-flight instruction always completes.
- Latency: ALU-type instruction = 3 cycles with zero-wait acks (FETCH, EXEC, COMMIT); load/store = 4 cycles.
- Instruction throughput with zero-wait acks is one per 3 cycles (4 for load/store).

Test Plan:
- Reset, then ADDI (0x00500093) with immediate i_ack -> IDLE 1 cycle; i_req next cycle; COMMIT in the 3rd cycle after IDLE with pc_inc=1, reg_write=1; pc_disable=0 only that cycle.
- BEQ (0x00000063) with alu_branch=1, then again with alu_branch=0 -> first COMMIT pc_branch=1, reg_write=0; second COMMIT pc_inc=1.
- LW (0x00002083) with d_ack delayed 3 cycles -> d_read high exactly 4 cycles, d_write=0; COMMIT pc_inc=1, reg_write=1.
- JAL (0x0000006F), then opcode 0x7F -> COMMIT pc_load=1 and reg_write=1; illegal_instr pulses 1 cycle in EXEC, COMMIT pc_inc=1, reg_write=0.
- i_ack never arrives with MEM_TIMEOUT=15 -> fault=1 after 15 FETCH cycles; state stays HALT with halt=0; clr low clears fault and returns to IDLE.
- halt raised during MEM of an SW, and clr pulsed low mid-FETCH -> SW completes COMMIT, then HALT until halt=0. clr drops i_req asynchronously and pc_disable=1 immediately.
